apb_master_ctrl: RTL and testbench
==================================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 255, max ACCESS wait cycles with PREADY low before forced termination; 0 disables the timeout.
REQ-002 Parameter: ADDR_W, 32, width of cmd_addr and PADDR.
REQ-003 PCLK  in  1  APB clock; all state changes on the rising edge.
REQ-004 PRESETn  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  local request for one APB transfer.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  ADDR_W  transfer address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_ready  out  1  block can accept a command.
REQ-010 rsp_valid  out  1  one-cycle pulse marking transfer completion.
REQ-011 rsp_rdata  out  32  read data; valid while rsp_valid=1.
REQ-012 rsp_err  out  1  transfer ended by timeout; valid while rsp_valid=1.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB control signals.
REQ-014 PADDR  out  ADDR_W, PWDATA  out  32  APB address and write data.
REQ-015 PRDATA  in  32, PREADY  in  1  APB read data and completer ready.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP and ACCESS, encoded as registers.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-018 On acceptance, the block SHALL register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and SHALL move IDLE->SETUP.
REQ-019 SETUP SHALL last exactly one cycle with PSEL=1 and PENABLE=0, then move unconditionally to ACCESS.
REQ-020 ACCESS SHALL drive PSEL=1 and PENABLE=1, and SHALL stay in ACCESS while PREADY=0.
REQ-021 PADDR, PWRITE and PWDATA SHALL stay constant from SETUP through the last ACCESS cycle.
REQ-022 On an ACCESS edge with PREADY=1, the block SHALL:
- capture PRDATA into rsp_rdata for reads (writes leave rsp_rdata unchanged);
- clear rsp_err;
- pulse rsp_valid for the following cycle;
- move to IDLE.
REQ-023 In IDLE, PSEL=0 and PENABLE=0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-024 Minimum latency SHALL be: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, rsp_valid=1 in cycle N+3 when PREADY=1 in the first ACCESS cycle.
REQ-025 Back-to-back commands SHALL have at least one IDLE cycle between transfers; cmd_ready=1 in the cycle where rsp_valid=1.
REQ-026 A wait counter SHALL clear on entering ACCESS and increment on each ACCESS edge with PREADY=0.
REQ-027 If TIMEOUT>0 and the counter equals TIMEOUT with PREADY still 0, the block SHALL:
- move to IDLE, dropping PSEL and PENABLE;
- pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-028 PREADY=1 on the same edge as the timeout condition SHALL complete normally (rsp_err=0); a normal completion takes priority over the timeout.
REQ-029 The block SHALL ignore PREADY and PRDATA outside ACCESS.
REQ-030 The block SHALL ignore cmd_valid outside IDLE; commands are neither queued nor dropped silently, because cmd_ready=0.

Reset
REQ-031 PRESETn=0 SHALL immediately force:
- IDLE, with the wait counter at 0;
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0;
- cmd_ready=0 while PRESETn=0, and 1 in the first cycle after release.
REQ-032 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid pulse.

Verification
REQ-033 Write 0x8C000000 <= 0x0000_1234 with PREADY tied to 1 -> PSEL high for 2 cycles, PENABLE high for 1, PWRITE=1, rsp_valid at N+3, rsp_err=0.
REQ-034 Read 0x8C000002 with PREADY low for 5 ACCESS cycles, PRDATA=0x0012_3456 -> ACCESS lasts 6 cycles, PADDR stable throughout, rsp_rdata=0x0012_3456.
REQ-035 TIMEOUT=4, read with PREADY held 0 -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 4 wait cycles, then PSEL=0.
REQ-036 TIMEOUT=4, PREADY rises on the 4th wait edge -> normal completion, rsp_err=0.
REQ-037 Assert PRESETn=0 mid-ACCESS -> PSEL, PENABLE and rsp_valid go 0 asynchronously; no response; the next command runs normally.
REQ-038 cmd_valid held high for 3 commands -> each transfer separated by at least 1 IDLE cycle, 3 rsp_valid pulses, SETUP never asserts PENABLE.

Source files
------------

// File: rtl/apb_master_ctrl.sv
// APB requester: takes one local command at a time and runs it as an APB
// SETUP/ACCESS transfer, with an optional ACCESS wait timeout.
module apb_master_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              cmd_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY
);

  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN  = (TIMEOUT > 0);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // completion wins over a timeout landing on the same edge
        if (PREADY) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b0;
          if (!pwrite_q) rdata_d = PRDATA;
          state_d  = IDLE;
        end else if (TO_EN && (cnt_q == TO_CNT)) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is gated by reset so it stays low for the whole reset pulse
  assign cmd_ready = PRESETn & (state_q == IDLE);
  assign PSEL      = (state_q != IDLE);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: one instance with TIMEOUT=4 and one with the
// timeout disabled, driven from a directed table, random transfers and corner sequences.
module tb_apb_master_ctrl;

  localparam int TO_A = 4;

  logic        PCLK, PRESETn;
  logic        sel;
  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, PRDATA;
  logic        PREADY;

  logic        a_rdy, a_rv, a_err, a_psel, a_pen, a_pwr;
  logic [31:0] a_rd, a_paddr, a_pwd;
  logic        b_rdy, b_rv, b_err, b_psel, b_pen, b_pwr;
  logic [31:0] b_rd, b_paddr, b_pwd;

  logic        o_rdy, o_rv, o_err, o_psel, o_pen, o_pwr;
  logic [31:0] o_rd, o_paddr, o_pwd;

  int n_cmp, n_bad;
  logic [31:0] mrd [2];

  apb_master_ctrl #(.TIMEOUT(TO_A), .ADDR_W(32)) u_a (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid & ~sel), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(a_rdy), .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_err),
    .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwr), .PADDR(a_paddr), .PWDATA(a_pwd),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_master_ctrl #(.TIMEOUT(0), .ADDR_W(32)) u_b (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid & sel), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(b_rdy), .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_err(b_err),
    .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwr), .PADDR(b_paddr), .PWDATA(b_pwd),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  assign o_rdy   = sel ? b_rdy   : a_rdy;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_err   = sel ? b_err   : a_err;
  assign o_psel  = sel ? b_psel  : a_psel;
  assign o_pen   = sel ? b_pen   : a_pen;
  assign o_pwr   = sel ? b_pwr   : a_pwr;
  assign o_rd    = sel ? b_rd    : a_rd;
  assign o_paddr = sel ? b_paddr : a_paddr;
  assign o_pwd   = sel ? b_pwd   : a_pwd;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", nm, act, exp);
    end
  endtask

  // One transfer, entered and left on a falling edge with the selected DUT idle.
  task automatic do_txn(input logic s, input logic wr, input logic [31:0] ad, input logic [31:0] wd,
                        input int w, input logic [31:0] prd,
                        input logic e_err, input logic [31:0] e_rd, input int e_acc);
    int acc;
    bit got, stab;
    sel = s;
    #1;
    chk("cmd_ready_idle", 32'(o_rdy), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = ad; cmd_wdata = wd;
    PREADY = 1'($urandom); PRDATA = $urandom;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk("setup_sel_en", 32'({o_psel, o_pen, o_rdy}), 32'b100);
    chk("setup_paddr", o_paddr, ad);
    chk("setup_pwrite", 32'(o_pwr), 32'(wr));
    chk("setup_pwdata", o_pwd, wd);
    PREADY = 1'b1; PRDATA = $urandom;
    acc = 0; got = 0; stab = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (o_rv) begin
        got = 1;
        break;
      end else if (o_psel && o_pen) begin
        if (o_paddr !== ad || o_pwr !== wr || o_pwd !== wd) stab = 0;
        PREADY = (acc >= w);
        PRDATA = (acc >= w) ? prd : $urandom;
        acc++;
      end else begin
        break;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("access_cycles", 32'(acc), 32'(e_acc));
    chk("hold_stable", 32'(stab), 32'd1);
    chk("rsp_err", 32'(o_err), 32'(e_err));
    chk("rsp_rdata", o_rd, e_rd);
    chk("rsp_cycle_idle", 32'({o_psel, o_pen, o_rdy}), 32'b001);
    PREADY = 1'($urandom); PRDATA = $urandom;
    @(negedge PCLK);
    chk("rsp_one_cycle", 32'(o_rv), 32'd0);
  endtask

  typedef struct {
    logic        s;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;
    logic [31:0] prd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_acc;
  } vec_t;

  vec_t vt [9];
  logic [2:0] b2b [11];

  initial begin
    int rv_cnt;
    bit rv_seen;
    n_cmp = 0; n_bad = 0;
    mrd[0] = '0; mrd[1] = '0;

    // s, wr, addr, wdata, wait, PRDATA, exp err, exp rdata, exp ACCESS cycles
    vt[0] = '{1'b0, 1'b1, 32'h8C00_0000, 32'h0000_1234, 0,  32'hAAAA_5555, 1'b0, 32'h0,         1};
    vt[1] = '{1'b0, 1'b0, 32'h8C00_0010, 32'h0,         2,  32'h0000_BEEF, 1'b0, 32'h0000_BEEF, 3};
    vt[2] = '{1'b0, 1'b0, 32'h8C00_0004, 32'h0,         9,  32'h1111_1111, 1'b1, 32'h0,         5};
    vt[3] = '{1'b0, 1'b0, 32'h8C00_0008, 32'h0,         3,  32'h0000_0333, 1'b0, 32'h0000_0333, 4};
    vt[4] = '{1'b0, 1'b0, 32'h8C00_000C, 32'h0,         4,  32'h0000_0444, 1'b0, 32'h0000_0444, 5};
    vt[5] = '{1'b0, 1'b1, 32'h8C00_0020, 32'h0000_CAFE, 1,  32'h9999_9999, 1'b0, 32'h0000_0444, 2};
    vt[6] = '{1'b0, 1'b1, 32'h8C00_0024, 32'h0000_F00D, 5,  32'h7777_7777, 1'b1, 32'h0,         5};
    vt[7] = '{1'b1, 1'b0, 32'h8C00_0002, 32'h0,         5,  32'h0012_3456, 1'b0, 32'h0012_3456, 6};
    vt[8] = '{1'b1, 1'b1, 32'h8C00_0030, 32'h0000_5678, 12, 32'h3333_3333, 1'b0, 32'h0012_3456, 13};

    // {PSEL, PENABLE, rsp_valid} with cmd_valid held high and PREADY=1
    b2b = '{3'b000, 3'b100, 3'b110, 3'b001, 3'b100, 3'b110,
            3'b001, 3'b100, 3'b110, 3'b001, 3'b000};

    sel = 1'b0; PRESETn = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'hFFFF_FFFF;
    PREADY = 1'b1; PRDATA = 32'hFFFF_FFFF;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("rst_ctrl", 32'({o_psel, o_pen, o_pwr, o_rv, o_err, o_rdy}), 32'd0);
    chk("rst_paddr", o_paddr, 32'd0);
    chk("rst_pwdata", o_pwd, 32'd0);
    chk("rst_rdata", o_rd, 32'd0);
    cmd_valid = 1'b0;
    PRESETn = 1'b1;
    #1;
    chk("ready_after_release", 32'(o_rdy), 32'd1);
    @(negedge PCLK);

    foreach (vt[i]) begin
      do_txn(vt[i].s, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].w, vt[i].prd,
             vt[i].e_err, vt[i].e_rd, vt[i].e_acc);
      mrd[vt[i].s] = vt[i].e_rd;
    end

    // Random transfers against the transfer-level model
    for (int i = 0; i < 30; i++) begin
      logic s, wr, e_err;
      logic [31:0] ad, wd, prd, e_rd;
      int w, to, e_acc;
      s = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
      ad = $urandom; wd = $urandom; prd = $urandom; w = $urandom_range(0, 7);
      to = s ? 0 : TO_A;
      if (to > 0 && w > to) begin
        e_err = 1'b1; e_rd = 32'h0; e_acc = to + 1;
      end else begin
        e_err = 1'b0; e_rd = wr ? mrd[s] : prd; e_acc = w + 1;
      end
      mrd[s] = e_rd;
      do_txn(s, wr, ad, wd, w, prd, e_err, e_rd, e_acc);
    end

    // Back-to-back with cmd_valid held high
    sel = 1'b0;
    #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; PREADY = 1'b1;
    rv_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge PCLK);
      if (c == 7) cmd_valid = 1'b0;
      cmd_addr = $urandom; cmd_wdata = $urandom;
      chk($sformatf("b2b_cycle%0d", c), 32'({o_psel, o_pen, o_rv}), 32'(b2b[c]));
      if (o_rv) rv_cnt++;
    end
    chk("b2b_rsp_count", 32'(rv_cnt), 32'd3);

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8C00_0040; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_reset_access", 32'({o_psel, o_pen}), 32'b11);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({o_psel, o_pen, o_rv, o_rdy}), 32'd0);
    chk("async_reset_paddr", o_paddr, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("ready_after_abort", 32'(o_rdy), 32'd1);
    rv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (o_rv || o_psel) rv_seen = 1;
    end
    chk("no_rsp_after_abort", 32'(rv_seen), 32'd0);
    mrd[0] = '0; mrd[1] = '0;
    do_txn(1'b0, 1'b0, 32'h8C00_0050, 32'h0, 1, 32'h5A5A_0001, 1'b0, 32'h5A5A_0001, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
